// File: rtl/eprom_programmer.sv
// EPROM program sequencer: optional erase, timed write strobes, optional read-back verify (EPROM_PGM_VERIFY_EN).
// Latency: erase ERASE_CYCLES, then per word 1 setup + WRITE_CYCLES strobe (+ settle + verify when enabled).
// Backpressure: src_ready is high only while waiting for a word; the sequencer holds in that state until src_valid.
module eprom_programmer #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 16,
    parameter int ERASE_CYCLES = 4,
    parameter int WRITE_CYCLES = 2,
    parameter int MAX_RETRY    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              erase_first,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_erase,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   words_done
);

    localparam int CNT_W   = 8;
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        IDLE, ERASE, WAIT_DATA, WRITE, SETTLE, VERIFY, DONE, FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                mem_we_d, mem_erase_d, src_ready_d, busy_d, done_d, error_d;
    logic [ADDR_W-1:0]   err_addr_d;
    logic [ADDR_W:0]     words_done_d, wd_inc;
    logic                word_cmp;

`ifndef EPROM_PGM_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            retry_q    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_erase  <= 1'b0;
            src_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_addr   <= '0;
            words_done <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_we     <= mem_we_d;
            mem_erase  <= mem_erase_d;
            src_ready  <= src_ready_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            err_addr   <= err_addr_d;
            words_done <= words_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_we_d     = mem_we;
        mem_erase_d  = mem_erase;
        error_d      = error;
        err_addr_d   = err_addr;
        words_done_d = words_done;
        wd_inc       = words_done + 1'b1;
        word_cmp     = 1'b0;

        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            mem_we_d    = 1'b0;
            mem_erase_d = 1'b0;
            cnt_d       = '0;
            retry_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_d       = start_addr;
                        count_d      = word_count;
                        words_done_d = '0;
                        error_d      = 1'b0;
                        retry_d      = '0;
                        cnt_d        = '0;
                        if (erase_first) begin
                            state_d     = ERASE;
                            mem_erase_d = 1'b1;
                        end else if (word_count == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = WAIT_DATA;
                        end
                    end
                end
                ERASE: begin
                    if (cnt_q == CNT_W'(ERASE_CYCLES - 1)) begin
                        mem_erase_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = (count_q == '0) ? DONE : WAIT_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (src_valid) begin
                        mem_addr_d  = addr_q;
                        mem_wdata_d = src_data;
                        cnt_d       = '0;
                        state_d     = WRITE;
                    end
                end
                WRITE: begin
                    // cnt 0 is the address/data setup cycle; the strobe spans cnt 1..WRITE_CYCLES
                    if (cnt_q == '0) begin
                        mem_we_d = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end else if (cnt_q == CNT_W'(WRITE_CYCLES)) begin
                        mem_we_d = 1'b0;
                        cnt_d    = '0;
`ifdef EPROM_PGM_VERIFY_EN
                        state_d  = SETTLE;
`else
                        word_cmp = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef EPROM_PGM_VERIFY_EN
                SETTLE: state_d = VERIFY;
                VERIFY: begin
                    if (mem_rdata == mem_wdata) begin
                        word_cmp = 1'b1;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        error_d    = 1'b1;
                        err_addr_d = mem_addr;
                        state_d    = FAIL;
                    end
                end
                FAIL: state_d = IDLE;
`endif
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (word_cmp) begin
                words_done_d = wd_inc;
                addr_d       = addr_q + 1'b1;
                retry_d      = '0;
                state_d      = (wd_inc == count_q) ? DONE : WAIT_DATA;
            end
        end

        src_ready_d = (state_d == WAIT_DATA);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

endmodule

// File: doc/eprom_programmer.md
Name: eprom_programmer

Overview:
- Sequencer that sits directly upstream of the 16x16 EPROM array and drives its addr/we/write_data/erase pins.
- Accepts a program job (start address, word count, optional erase) plus a valid/ready word stream.
- Erases the array if requested, writes each word with a timed write strobe, and optionally reads each word back to verify it.
- Reports busy, done and error status to the host controller.

Parameters:
- ADDR_W, 4, EPROM address width; DEPTH = 2**ADDR_W words.
- DATA_W, 16, EPROM word width.
- ERASE_CYCLES, 4, cycles mem_erase is held high; must be >= 1.
- WRITE_CYCLES, 2, cycles mem_we is held high per write attempt; must be >= 1.
- MAX_RETRY, 2, extra write attempts after a verify mismatch (verify build only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- erase_first  in  1  erase the whole array before writing; sampled with start.
- start_addr  in  ADDR_W  first word address; sampled with start.
- word_count  in  ADDR_W+1  number of words, 0..DEPTH; sampled with start.
- abort  in  1  synchronous job abort.
- src_valid  in  1  source word valid.
- src_data  in  DATA_W  source word.
- src_ready  out  1  high only in WAIT_DATA.
- mem_addr  out  ADDR_W  to EPROM addr.
- mem_we  out  1  to EPROM we.
- mem_wdata  out  DATA_W  to EPROM write_data.
- mem_erase  out  1  to EPROM erase.
- mem_rdata  in  DATA_W  from EPROM data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a job completes without error.
- error  out  1  sticky; cleared by the next accepted start.
- err_addr  out  ADDR_W  address of the failing word.
- words_done  out  ADDR_W+1  words successfully written in the current job.

Behaviour:
- All outputs are registered. Async reset drives every output and internal register to 0 and the FSM to IDLE.
- States: IDLE, ERASE, WAIT_DATA, WRITE, SETTLE, VERIFY, DONE, FAIL.

IDLE:
- When start=1: latch the job inputs, clear error and words_done.
- Next state: ERASE if erase_first=1; else DONE if word_count=0; else WAIT_DATA.

ERASE:
- mem_erase=1 for exactly ERASE_CYCLES cycles; mem_we=0 throughout.
- Then go to DONE if word_count=0, else WAIT_DATA.

WAIT_DATA:
- src_ready=1. A transfer occurs on a cycle with src_valid=1 and src_ready=1.
- On transfer: capture src_data into mem_wdata, set mem_addr to the current address, go to WRITE.
- src_ready is 0 in all other states; src_valid is ignored there.

WRITE:
- mem_we=1 for WRITE_CYCLES cycles.
- mem_addr and mem_wdata must be stable one cycle before mem_we rises and stay stable until after it falls. mem_erase and mem_we are never high together.
- Next state: SETTLE (verify build) or the word-complete step (non-verify build).

SETTLE:
- Exactly one cycle with mem_we=0 so the combinational EPROM read path settles.

VERIFY:
- Compare mem_rdata against mem_wdata.
- Match: go to the word-complete step.
- Mismatch with retries remaining: increment the retry counter and return to WRITE with the same addr/data.
- Mismatch with retries exhausted: go to FAIL.

Word complete:
- words_done increments; the address increments modulo DEPTH (DEPTH-1 wraps to 0); the retry counter clears.
- Go to DONE if words_done equals word_count, else WAIT_DATA.

DONE:
- done=1 for one cycle, then IDLE.

FAIL:
- error=1, err_addr = the failing address, then IDLE. done is not pulsed.

Abort:
- abort=1 in any non-IDLE state forces IDLE on the next edge and drops mem_we, mem_erase and src_ready that same edge.
- No done pulse; error is unchanged.
- abort has priority over all other transitions.

Other rules:
- start=1 while busy is ignored. A start asserted together with abort in IDLE is accepted.
- Reset asserted mid-write or mid-erase drops all strobes immediately (asynchronously).

Optional Feature:
- Macro: EPROM_PGM_VERIFY_EN.
- Defined: SETTLE/VERIFY states and the retry logic are present, and error can assert.
- Undefined: WRITE goes straight to the word-complete step, MAX_RETRY is unused, and error and err_addr are tied to 0.

Test Plan:
- Erase then 3-word program: start_addr=2, word_count=3, erase_first=1, stream 16'hA5A5/16'h1234/16'hFFFF -> mem_erase high for 4 cycles; then locations 2,3,4 hold those values, done pulses once, words_done=3, error=0.
- Wrap-around: start_addr=15, word_count=2, words 16'h0011/16'h0022 -> writes at addresses 15 then 0; addresses 1..14 untouched.
- Backpressure: src_valid low for 5 cycles mid-job -> FSM holds in WAIT_DATA with mem_we=0 and src_ready=1; job completes normally when valid returns.
- Verify failure (VERIFY_EN): bench forces mem_rdata=16'h0000 for addr 5 when writing 16'h00FF -> exactly 3 write strobes at addr 5, error=1, err_addr=5, no done pulse.
- Abort during WRITE -> mem_we low on the next edge, busy=0, done=0; a new start is accepted afterwards and clears error.
- Reset mid-erase (rst_n low during ERASE) -> mem_erase=0 immediately, all outputs 0, FSM in IDLE.
